alu_arbiter: RTL and testbench

Shares the single combinational `alu` between two requesters (port 0: integer pipeline issue, port 1: branch/compare unit). It uses a valid/ready request handshake and round-robin arbitration. Each granted operation's operands are registered, evaluated by one `alu` instance, and returned on a single response channel tagged with the requester ID. The result is held until the consumer accepts it.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu.sv | 33 +++
 rtl/alu_arbiter.sv | 103 ++++++++++
 tb/tb_alu_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Opcode constants and arbiter state type shared by alu and alu_arbiter.
package alu_pkg;
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_EQ   = 4'b1010;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;
endpackage

// File: rtl/alu.sv
// Combinational ALU, zero latency, no handshake; undefined opcodes return 1.
// Shift amounts use the full SrcB value, so shifts of width or more clear (or sign-fill).
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] ALUControl,
  output logic [DATA_WIDTH-1:0]    ALUResult
);
  localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    ALUResult = ONE;
    case (ALUControl)
      ALU_ADD:  ALUResult = SrcA + SrcB;
      ALU_SUB:  ALUResult = SrcA - SrcB;
      ALU_XOR:  ALUResult = SrcA ^ SrcB;
      ALU_OR:   ALUResult = SrcA | SrcB;
      ALU_AND:  ALUResult = SrcA & SrcB;
      ALU_SRL:  ALUResult = SrcA >> SrcB;
      ALU_SLL:  ALUResult = SrcA << SrcB;
      ALU_SRA:  ALUResult = $unsigned($signed(SrcA) >>> SrcB);
      ALU_SLT:  ALUResult = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      ALU_SLTU: ALUResult = {{(DATA_WIDTH-1){1'b0}}, (SrcA < SrcB)};
      ALU_EQ:   ALUResult = {{(DATA_WIDTH-1){1'b0}}, (SrcA == SrcB)};
      default:  ALUResult = ONE;
    endcase
  end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one alu between two requesters; accept-to-response 2 cycles, 1 op per 3 cycles.
// Response is held until rsp_ready; request ready is only offered while idle.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [DATA_WIDTH-1:0]    req0_srca,
  input  logic [DATA_WIDTH-1:0]    req0_srcb,
  input  logic [OPCODE_LENGTH-1:0] req0_op,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [DATA_WIDTH-1:0]    req1_srca,
  input  logic [DATA_WIDTH-1:0]    req1_srcb,
  input  logic [OPCODE_LENGTH-1:0] req1_op,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_id,
  output logic [DATA_WIDTH-1:0]    rsp_result
);
  arb_state_t                r_state;
  arb_state_t                w_next_state;
  logic                      r_last_grant;
  logic [DATA_WIDTH-1:0]     r_op_srca;
  logic [DATA_WIDTH-1:0]     r_op_srcb;
  logic [OPCODE_LENGTH-1:0]  r_op_code;
  logic                      r_op_id;
  logic                      r_rsp_id;
  logic [DATA_WIDTH-1:0]     r_rsp_result;
  logic                      w_grant_vld;
  logic                      w_grant_id;
  logic [DATA_WIDTH-1:0]     w_alu_result;

  always_comb begin
    w_next_state = r_state;
    w_grant_vld  = 1'b0;
    w_grant_id   = 1'b0;
    case (r_state)
      IDLE: begin
        w_grant_vld = req0_valid | req1_valid;
        // On contention the requester that lost last time wins.
        w_grant_id  = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
        if (w_grant_vld) w_next_state = EXEC;
      end
      EXEC:    w_next_state = RESP;
      RESP:    if (rsp_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  assign req0_ready = w_grant_vld & ~w_grant_id;
  assign req1_ready = w_grant_vld &  w_grant_id;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_op_srca    <= '0;
      r_op_srcb    <= '0;
      r_op_code    <= '0;
      r_op_id      <= 1'b0;
    end else if (w_grant_vld) begin
      r_last_grant <= w_grant_id;
      r_op_srca    <= w_grant_id ? req1_srca : req0_srca;
      r_op_srcb    <= w_grant_id ? req1_srcb : req0_srcb;
      r_op_code    <= w_grant_id ? req1_op   : req0_op;
      r_op_id      <= w_grant_id;
    end
  end

  alu #(
    .DATA_WIDTH    (DATA_WIDTH),
    .OPCODE_LENGTH (OPCODE_LENGTH)
  ) u_alu (
    .SrcA       (r_op_srca),
    .SrcB       (r_op_srcb),
    .ALUControl (r_op_code),
    .ALUResult  (w_alu_result)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_result <= '0;
      r_rsp_id     <= 1'b0;
    end else if (r_state == EXEC) begin
      r_rsp_result <= w_alu_result;
      r_rsp_id     <= r_op_id;
    end
  end

  assign rsp_valid  = (r_state == RESP);
  assign rsp_result = r_rsp_result;
  assign rsp_id     = r_rsp_id;
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized run against a transaction model.
module tb_alu_arbiter;
  localparam int DW = 32;
  localparam int OL = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DW-1:0] req0_srca, req0_srcb, req1_srca, req1_srcb;
  logic [OL-1:0] req0_op, req1_op;
  logic          rsp_valid, rsp_ready, rsp_id;
  logic [DW-1:0] rsp_result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_srca(req0_srca),
    .req0_srcb(req0_srcb), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_srca(req1_srca),
    .req1_srcb(req1_srcb), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result)
  );

  function automatic logic [31:0] alu_model(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a ^ b;
      4'd3:    return a | b;
      4'd4:    return a & b;
      4'd5:    return a >> b;
      4'd6:    return a << b;
      4'd7:    return $unsigned($signed(a) >>> b);
      4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:    return (a < b) ? 32'd1 : 32'd0;
      4'd10:   return (a == b) ? 32'd1 : 32'd0;
      default: return 32'd1;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_grant(output logic id, output logic ok);
    ok = 1'b0;
    id = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        ok = 1'b1;
        id = req1_ready;
      end
    end
  endtask

  task automatic wait_rsp(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_srca = '0; req0_srcb = '0; req0_op = '0;
    req1_srca = '0; req1_srcb = '0; req1_op = '0;
    repeat (2) @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    n_checks++; if (rsp_result !== 32'd0) begin n_fail++; $display("FAIL reset_rsp_result: got %h expected 0", rsp_result); end
    n_checks++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_id: got %b expected 0", rsp_id); end
    n_checks++; if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready}); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic gid, ok;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req0_op = 4'd0; req0_srca = 32'd5; req0_srcb = 32'd7; req0_valid = 1'b1;
    wait_grant(gid, ok);
    n_checks++; if (!ok || gid !== 1'b0 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL single_grant: ok=%b id=%b r1=%b expected ok=1 id=0 r1=0", ok, gid, req1_ready); end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_exec_valid: got %b expected 0", rsp_valid); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd12 || rsp_id !== 1'b0) begin n_fail++; $display("FAIL single_rsp: valid=%b result=%h id=%b expected 1/0000000c/0", rsp_valid, rsp_result, rsp_id); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp_one_cycle: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_contention();
    logic gid, ok;
    do_reset();
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req0_op = 4'd1; req0_srca = 32'd10; req0_srcb = 32'd3; req0_valid = 1'b1;
    req1_op = 4'd8; req1_srca = 32'hFFFF_FFFF; req1_srcb = 32'd1; req1_valid = 1'b1;
    wait_grant(gid, ok);
    n_checks++; if (!ok || gid !== 1'b0 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL contention_first_grant: ok=%b id=%b r1=%b expected ok=1 id=0 r1=0", ok, gid, req1_ready); end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (req1_ready !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL contention_exec: r1=%b valid=%b expected 0/0", req1_ready, rsp_valid); end
    @(negedge clk);
    n_checks++; if (req1_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_result !== 32'd7 || rsp_id !== 1'b0) begin n_fail++; $display("FAIL contention_rsp0: r1=%b valid=%b result=%h id=%b expected 0/1/00000007/0", req1_ready, rsp_valid, rsp_result, rsp_id); end
    wait_grant(gid, ok);
    n_checks++; if (!ok || gid !== 1'b1) begin n_fail++; $display("FAIL contention_second_grant: ok=%b id=%b expected ok=1 id=1", ok, gid); end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_rsp(ok);
    n_checks++; if (!ok || rsp_result !== 32'd1 || rsp_id !== 1'b1) begin n_fail++; $display("FAIL contention_rsp1: ok=%b result=%h id=%b expected 1/00000001/1", ok, rsp_result, rsp_id); end
  endtask

  task automatic test_fairness();
    logic gid, ok;
    logic [31:0] exp_res;
    do_reset();
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req0_op = 4'($urandom_range(0, 10)); req0_srca = $urandom; req0_srcb = $urandom_range(0, 31);
    req1_op = 4'($urandom_range(0, 10)); req1_srca = $urandom; req1_srcb = $urandom_range(0, 31);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_grant(gid, ok);
      n_checks++; if (!ok || gid !== 1'(i % 2)) begin n_fail++; $display("FAIL fairness_grant[%0d]: ok=%b id=%b expected %0d", i, ok, gid, i % 2); end
      exp_res = gid ? alu_model(req1_op, req1_srca, req1_srcb) : alu_model(req0_op, req0_srca, req0_srcb);
      @(posedge clk); #1;
      // Scramble the winner's inputs once the grant has been taken.
      if (gid) begin req1_op = 4'($urandom_range(0, 10)); req1_srca = $urandom; req1_srcb = $urandom_range(0, 31); end
      else     begin req0_op = 4'($urandom_range(0, 10)); req0_srca = $urandom; req0_srcb = $urandom_range(0, 31); end
      wait_rsp(ok);
      n_checks++; if (!ok || rsp_result !== exp_res || rsp_id !== gid) begin n_fail++; $display("FAIL fairness_rsp[%0d]: ok=%b result=%h id=%b expected %h/%b", i, ok, rsp_result, rsp_id, exp_res, gid); end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic gid, ok;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req1_op = 4'd10; req1_srca = 32'h55; req1_srcb = 32'h55; req1_valid = 1'b1;
    wait_grant(gid, ok);
    n_checks++; if (!ok || gid !== 1'b1) begin n_fail++; $display("FAIL bp_grant: ok=%b id=%b expected ok=1 id=1", ok, gid); end
    @(posedge clk); #1;
    req1_valid = 1'b0; req1_srca = 32'h1234;
    req0_op = 4'd0; req0_srca = 32'd1; req0_srcb = 32'd1; req0_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd1 || rsp_id !== 1'b1 || req0_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold[%0d]: valid=%b result=%h id=%b r0=%b expected 1/00000001/1/0", i, rsp_valid, rsp_result, rsp_id, req0_ready); end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0 || req0_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: valid=%b r0=%b expected 0/1", rsp_valid, req0_ready); end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wait_rsp(ok);
    n_checks++; if (!ok || rsp_result !== 32'd2 || rsp_id !== 1'b0) begin n_fail++; $display("FAIL bp_next_rsp: ok=%b result=%h id=%b expected 1/00000002/0", ok, rsp_result, rsp_id); end
  endtask

  task automatic test_reset_mid();
    logic gid, ok;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req0_op = 4'd3; req0_srca = 32'hF0; req0_srcb = 32'h0F; req0_valid = 1'b1;
    wait_grant(gid, ok);
    n_checks++; if (!ok || gid !== 1'b0) begin n_fail++; $display("FAIL rmid_grant: ok=%b id=%b expected ok=1 id=0", ok, gid); end
    @(posedge clk); #1;
    reset = 1'b1; req0_valid = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b0 || rsp_result !== 32'd0 || rsp_id !== 1'b0) begin n_fail++; $display("FAIL rmid_clear: valid=%b result=%h id=%b expected 0/0/0", rsp_valid, rsp_result, rsp_id); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_no_rsp[%0d]: valid=%b expected 0", i, rsp_valid); end
    end
    @(posedge clk); #1;
    req0_op = 4'd0; req0_srca = 32'd3; req0_srcb = 32'd4; req0_valid = 1'b1;
    req1_op = 4'd0; req1_srca = 32'd9; req1_srcb = 32'd9; req1_valid = 1'b1;
    wait_grant(gid, ok);
    n_checks++; if (!ok || gid !== 1'b0) begin n_fail++; $display("FAIL rmid_first_after_reset: ok=%b id=%b expected ok=1 id=0", ok, gid); end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp(ok);
    n_checks++; if (!ok || rsp_result !== 32'd7 || rsp_id !== 1'b0) begin n_fail++; $display("FAIL rmid_rsp: ok=%b result=%h id=%b expected 1/00000007/0", ok, rsp_result, rsp_id); end
  endtask

  task automatic test_undef_opcode();
    logic gid, ok;
    logic [3:0]  ops [6] = '{4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111, 4'b0111};
    logic [31:0] exp_res;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      req0_op = ops[i];
      req0_srca = (i == 5) ? 32'h8000_0000 : $urandom;
      req0_srcb = (i == 5) ? 32'd4 : $urandom;
      req0_valid = 1'b1;
      exp_res = (i == 5) ? alu_model(req0_op, req0_srca, req0_srcb) : 32'd1;
      wait_grant(gid, ok);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      wait_rsp(ok);
      n_checks++; if (!ok || rsp_result !== exp_res || rsp_id !== 1'b0) begin n_fail++; $display("FAIL undef_op[%b]: ok=%b result=%h id=%b expected %h/0", ops[i], ok, rsp_result, rsp_id, exp_res); end
    end
  endtask

  task automatic test_random();
    logic busy, exp_vld, exp_r0, exp_r1, last, exp_id;
    logic [31:0] exp_res;
    int age;
    do_reset();
    busy = 1'b0; age = 0; last = 1'b1; exp_id = 1'b0; exp_res = '0;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_op = 4'($urandom_range(0, 15)); req0_srca = $urandom;
      req0_srcb = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 40));
      req1_op = 4'($urandom_range(0, 15)); req1_srca = $urandom;
      req1_srcb = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 40));
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      exp_vld = busy && (age >= 2);
      exp_r0  = !busy && req0_valid && (!req1_valid || last);
      exp_r1  = !busy && req1_valid && (!req0_valid || !last);
      n_checks++; if (req0_ready !== exp_r0) begin n_fail++; $display("FAIL rand_r0[%0d]: got %b expected %b", c, req0_ready, exp_r0); end
      n_checks++; if (req1_ready !== exp_r1) begin n_fail++; $display("FAIL rand_r1[%0d]: got %b expected %b", c, req1_ready, exp_r1); end
      n_checks++; if (rsp_valid !== exp_vld) begin n_fail++; $display("FAIL rand_rsp_valid[%0d]: got %b expected %b", c, rsp_valid, exp_vld); end
      if (exp_vld) begin
        n_checks++; if (rsp_result !== exp_res || rsp_id !== exp_id) begin n_fail++; $display("FAIL rand_rsp[%0d]: result=%h id=%b expected %h/%b", c, rsp_result, rsp_id, exp_res, exp_id); end
      end
      if (busy) begin
        if (exp_vld && rsp_ready) busy = 1'b0;
        else age++;
      end else if (req0_valid || req1_valid) begin
        exp_id  = exp_r1;
        exp_res = exp_r1 ? alu_model(req1_op, req1_srca, req1_srcb) : alu_model(req0_op, req0_srca, req0_srcb);
        last    = exp_r1;
        busy    = 1'b1;
        age     = 1;
      end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_undef_opcode();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
